// File: rtl/imem_loader_arbiter.sv
// ============================================================================
// imem_loader_arbiter : shares the instruction-memory port between CPU fetch
//                       and a byte-stream program loader (MSB-first words).
// Optional checksum byte after the last word: IMEM_LOADER_CHECKSUM_EN
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader_arbiter #(
   parameter int DEPTH = 64,
   parameter int LEN_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      fetch_a,
   output logic [31:0]      fetch_rd,
   output logic             cpu_stall,
   input  logic             load_start,
   input  logic [LEN_W-1:0] load_len,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             load_done,
   output logic             load_err,
   output logic [31:0]      mem_a,
   output logic [31:0]      mem_wd,
   output logic             mem_we,
   input  logic [31:0]      mem_rd
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_RUN,
      S_COLLECT,
      S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [IDX_W-1:0]   word_idx_q, word_idx_d;
   logic [1:0]         byte_cnt_q, byte_cnt_d;
   logic [31:0]        word_q, word_d;
   logic               last_word;
   logic [LEN_W-1:0]   len_clamped;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]         chk_q, chk_d;
   logic               err_q, err_d;
`endif

   // Zero or oversize lengths load the whole memory, so word_idx never wraps.
   assign len_clamped = (load_len == '0 || load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : load_len;
   assign last_word   = ({1'b0, word_idx_q} + LEN_W'(1)) == len_q;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_d      = chk_q;
      err_d      = err_q;
`endif
      mem_a      = fetch_a;
      fetch_rd   = mem_rd;
      cpu_stall  = 1'b0;
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      mem_wd     = 32'h0000_0000;
      load_done  = 1'b0;

      if (state_q != S_RUN) begin
         mem_a     = {{(30-IDX_W){1'b0}}, word_idx_q, 2'b00};
         fetch_rd  = 32'h0000_0000;
         cpu_stall = 1'b1;
      end

      case (state_q)
         S_RUN: begin
            if (load_start) begin
               len_d      = len_clamped;
               word_idx_d = '0;
               byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_d      = 8'h00;
               err_d      = 1'b0;
`endif
               state_d    = S_COLLECT;
            end
         end
         S_COLLECT: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               word_d     = {word_q[23:0], byte_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_d      = chk_q ^ byte_data;
`endif
               if (byte_cnt_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_we = 1'b1;
            mem_wd = word_q;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else begin
               word_idx_d = word_idx_q + IDX_W'(1);
               state_d    = S_COLLECT;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               if (byte_data != chk_q) err_d = 1'b1;
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            load_done = 1'b1;
            state_d   = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_RUN;
         len_q      <= '0;
         word_idx_q <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_idx_q <= word_idx_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk_q      <= chk_d;
         err_q      <= err_d;
`endif
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign load_err = err_q;
`else
   assign load_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader_arbiter.sv
// ============================================================================
// tb_imem_loader_arbiter : scoreboard bench for imem_loader_arbiter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader_arbiter;

   localparam int DEPTH = 64;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   fetch_a;
   logic [31:0]   fetch_rd;
   logic          cpu_stall;
   logic          load_start;
   logic [LW-1:0] load_len;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          load_done;
   logic          load_err;
   logic [31:0]   mem_a;
   logic [31:0]   mem_wd;
   logic          mem_we;
   logic [31:0]   mem_rd;

   imem_loader_arbiter #(.DEPTH(DEPTH), .LEN_W(LW)) dut (
      .clk        (clk),
      .reset      (reset),
      .fetch_a    (fetch_a),
      .fetch_rd   (fetch_rd),
      .cpu_stall  (cpu_stall),
      .load_start (load_start),
      .load_len   (load_len),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .load_done  (load_done),
      .load_err   (load_err),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_we     (mem_we),
      .mem_rd     (mem_rd)
   );

   always #5 clk = ~clk;

   // Memory model; the bench preloads through its own side port.
   logic [31:0] mem [DEPTH];
   logic        tb_we = 1'b0;
   logic [5:0]  tb_wa = '0;
   logic [31:0] tb_wd = '0;
   assign mem_rd = mem[mem_a[7:2]];
   always @(posedge clk) begin
      if (mem_we)     mem[mem_a[7:2]] <= mem_wd;
      else if (tb_we) mem[tb_wa]      <= tb_wd;
   end

   logic [63:0] exp_q [$];
   logic [31:0] ld_words [DEPTH];
   int          vectors     = 0;
   int          miscompares = 0;
   int          stall_cnt   = 0;
   int          done_cnt    = 0;
   logic        err_at_done = 1'b0;

   // One cycle of observation: counts stall/done and checks every memory write.
   task automatic tick();
      logic [63:0] e;
      @(negedge clk);
      if (cpu_stall) stall_cnt++;
      if (load_done) begin
         done_cnt++;
         err_at_done = load_err;
      end
      if (mem_we) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: a=%h d=%h, expected no write", mem_a, mem_wd);
         end else begin
            e = exp_q.pop_front();
            if ({mem_a, mem_wd} !== e) begin
               miscompares++;
               $display("FAIL mem_write: got a=%h d=%h, expected a=%h d=%h",
                        mem_a, mem_wd, e[63:32], e[31:0]);
            end
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      for (int t = 0; t < 50; t++) begin
         tick();
         if (byte_ready) begin
            ok = 1;
            break;
         end
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL byte_ready_timeout: byte %h not accepted, expected acceptance", b);
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   task automatic start_load(input logic [LW-1:0] len);
      @(posedge clk); #1;
      load_start = 1'b1;
      load_len   = len;
      tick();
      @(posedge clk); #1;
      load_start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (!cpu_stall) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL idle_timeout: cpu_stall still 1, expected 0");
      end
   endtask

   // Loads n words from ld_words; gaps idle cycles are inserted before byte gap_at.
   task automatic run_load(input int n, input logic [LW-1:0] len, input int gap_at,
                           input int gaps, input logic [7:0] chk_flip,
                           output int stall, output int dones);
      int s0, d0;
      logic [7:0]  x;
      logic [31:0] w;
      s0 = stall_cnt;
      d0 = done_cnt;
      x  = 8'h00;
      for (int i = 0; i < n; i++) exp_q.push_back({32'(i * 4), ld_words[i]});
      start_load(len);
      for (int i = 0; i < n; i++) begin
         w = ld_words[i];
         for (int b = 0; b < 4; b++) begin
            if (i * 4 + b == gap_at) begin
               repeat (gaps) begin
                  tick();
                  @(posedge clk); #1;
               end
            end
            x = x ^ w[31-8*b -: 8];
            send_byte(w[31-8*b -: 8]);
         end
      end
      if (CHK == 1) send_byte(x ^ chk_flip);
      wait_idle();
      stall = stall_cnt - s0;
      dones = done_cnt - d0;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_writes: %0d outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      fetch_a = 32'h0000_0020;
      load_start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (3) @(posedge clk);
      tick();
      vectors++;
      if ({cpu_stall, byte_ready, mem_we, load_done, load_err} !== 5'b0 || mem_wd !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: stall/rdy/we/done/err=%b wd=%h, expected 00000 wd=0",
                  {cpu_stall, byte_ready, mem_we, load_done, load_err}, mem_wd);
      end
      vectors++;
      if (mem_a !== 32'h0000_0020) begin
         miscompares++;
         $display("FAIL reset_mem_a: got %h, expected 00000020", mem_a);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_passthrough();
      @(posedge clk); #1;
      tb_we = 1'b1; tb_wa = 6'd2; tb_wd = 32'hE080_2001;
      @(posedge clk); #1;
      tb_we = 1'b0;
      fetch_a = 32'h0000_0008;
      tick();
      vectors++;
      if (fetch_rd !== 32'hE080_2001 || cpu_stall !== 1'b0 || mem_a !== 32'h8) begin
         miscompares++;
         $display("FAIL passthrough: rd=%h stall=%b a=%h, expected e0802001 0 00000008",
                  fetch_rd, cpu_stall, mem_a);
      end
   endtask

   task automatic check_load(input string name, input int stall, input int dones,
                             input int exp_stall, input logic exp_err);
      vectors++;
      if (stall !== exp_stall) begin
         miscompares++;
         $display("FAIL %s_stall: got %0d cycles, expected %0d", name, stall, exp_stall);
      end
      vectors++;
      if (dones !== 1) begin
         miscompares++;
         $display("FAIL %s_done: got %0d pulses, expected 1", name, dones);
      end
      vectors++;
      if (err_at_done !== exp_err || load_err !== exp_err) begin
         miscompares++;
         $display("FAIL %s_err: at_done=%b now=%b, expected %b", name, err_at_done, load_err, exp_err);
      end
   endtask

   task automatic test_two_word();
      int s, d;
      ld_words[0] = 32'hE3A0_000A;
      ld_words[1] = 32'hE3A0_1005;
      run_load(2, LW'(2), -1, 0, 8'h00, s, d);
      check_load("two_word", s, d, 11 + CHK, 1'b0);
   endtask

   task automatic test_gaps();
      int s, d;
      run_load(2, LW'(2), 2, 3, 8'h00, s, d);
      check_load("gaps", s, d, 14 + CHK, 1'b0);
   endtask

   task automatic test_clamp();
      int s, d;
      for (int i = 0; i < DEPTH; i++) ld_words[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
      run_load(DEPTH, LW'(0), -1, 0, 8'h00, s, d);
      check_load("clamp", s, d, 5 * DEPTH + 1 + CHK, 1'b0);
   endtask

   task automatic test_reset_mid_load();
      int d0;
      logic [31:0] w;
      logic [31:0] old1;
      old1 = ld_words[1];
      d0 = done_cnt;
      fetch_a = 32'h0000_0004;
      ld_words[0] = 32'hCAFE_F00D;
      exp_q.push_back({32'h0, 32'hCAFE_F00D});
      start_load(LW'(2));
      for (int k = 0; k < 6; k++) begin
         w = (k < 4) ? 32'hCAFE_F00D : 32'h1234_5678;
         send_byte(w[31-8*(k%4) -: 8]);
      end
      reset = 1'b1;
      tick();
      @(posedge clk); #1;
      reset = 1'b0;
      tick();
      vectors++;
      if (cpu_stall !== 1'b0 || byte_ready !== 1'b0 || mem_a !== 32'h4) begin
         miscompares++;
         $display("FAIL reset_mid_state: stall=%b rdy=%b a=%h, expected 0 0 00000004",
                  cpu_stall, byte_ready, mem_a);
      end
      vectors++;
      if (fetch_rd !== old1) begin
         miscompares++;
         $display("FAIL reset_mid_word1: got %h, expected untouched %h", fetch_rd, old1);
      end
      vectors++;
      if (done_cnt !== d0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL reset_mid_done: dones=%0d pending=%0d, expected 0 0",
                  done_cnt - d0, exp_q.size());
         exp_q.delete();
      end
      ld_words[0] = 32'hCAFE_F00D;
      fetch_a = 32'h0000_0000;
      tick();
      vectors++;
      if (fetch_rd !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("FAIL reset_mid_word0: got %h, expected cafef00d", fetch_rd);
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int s, d;
      ld_words[0] = 32'h0102_0304;
      run_load(1, LW'(1), -1, 0, 8'h00, s, d);
      check_load("chk_match", s, d, 7, 1'b0);
      run_load(1, LW'(1), -1, 0, 8'h01, s, d);
      check_load("chk_mismatch", s, d, 7, 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
         tick();
      end
      vectors++;
      if (load_err !== 1'b1) begin
         miscompares++;
         $display("FAIL chk_hold: got %b, expected 1", load_err);
      end
      start_load(LW'(1));
      tick();
      vectors++;
      if (load_err !== 1'b0) begin
         miscompares++;
         $display("FAIL chk_clear: got %b, expected 0", load_err);
      end
      exp_q.push_back({32'h0, 32'h0102_0304});
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h04);
      wait_idle();
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_passthrough();
      test_two_word();
      test_gaps();
      test_clamp();
      test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_loader_arbiter.md
# imem_loader_arbiter

Owns the single port of the writable instruction memory and shares it between the processor's fetch path and a byte-stream program loader. While running, fetch addresses pass straight through to memory. On a load request it stalls the CPU, assembles incoming bytes into 32-bit words, writes them to consecutive word addresses starting at 0, then releases the CPU. Sits between the fetch stage / PC logic and the instruction memory.

## Interface

Parameters:
- DEPTH, 64, instruction memory size in 32-bit words; power of two.
- LEN_W, $clog2(DEPTH)+1, width of `load_len`.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_a  in  32  CPU fetch byte address (PC).
- fetch_rd  out  32  instruction returned to the CPU.
- cpu_stall  out  1  high whenever the loader owns memory.
- load_start  in  1  one-cycle request to begin a load; honoured only in RUN.
- load_len  in  LEN_W  number of words to load; sampled with `load_start`.
- byte_valid  in  1  loader byte available.
- byte_data  in  8  loader byte.
- byte_ready  out  1  block accepts a byte this cycle.
- load_done  out  1  one-cycle pulse at load completion.
- load_err  out  1  checksum mismatch flag (see Configuration).
- mem_a  out  32  memory byte address.
- mem_wd  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_rd  in  32  memory read data (combinational read).

## Operation

- **States:** RUN, COLLECT, WRITE, CHECK (macro only), DONE.
- **RUN:**
  - `mem_a` = `fetch_a`; `fetch_rd` = `mem_rd`; `cpu_stall` = 0; `mem_we` = 0.
  - `load_start` = 1 captures the length into `len_q`, clears `word_idx`, `byte_cnt` and the checksum accumulator, clears `load_err`, and moves to COLLECT.
  - `load_len` = 0 or `load_len` > DEPTH loads DEPTH words.
- **Non-RUN states:** `mem_a` = {`word_idx`, 2'b00}; `fetch_rd` = 32'h0000_0000; `cpu_stall` = 1.
- **COLLECT:**
  - `byte_ready` = 1.
  - Each cycle with `byte_valid` & `byte_ready` shifts the byte into `word_q`, MSB first: the first byte lands in [31:24] and the fourth in [7:0].
  - `byte_cnt` increments; on the 4th byte, go to WRITE.
- **WRITE:**
  - `mem_we` = 1, `mem_wd` = `word_q`, `byte_ready` = 0, for exactly one cycle.
  - Then `word_idx` increments.
  - If `word_idx` + 1 == `len_q`, go to CHECK (macro) or DONE; otherwise go to COLLECT.
- **DONE:** `load_done` = 1 for one cycle, then RUN. `cpu_stall` drops on the RUN cycle.
- **`load_start` outside RUN:** ignored.
- **`byte_valid` outside COLLECT/CHECK:** ignored. The producer holds the byte until `byte_ready`.
- **Reset mid-load:** return to RUN with all counters cleared. Words already written remain in memory; no partial word is written.
- **Counter widths:** `word_idx` is $clog2(DEPTH) bits and never wraps, because the length is clamped to DEPTH.

## Timing

- **Reset values:**
  - `cpu_stall`, `byte_ready`, `mem_we`, `load_done`, `load_err` = 0.
  - `mem_wd` = 0.
  - `mem_a` follows `fetch_a`.
- **Fetch path:** combinational, zero cycles of added latency in RUN.
- **Handshake timing:**
  - `load_start` seen at edge N puts the block in COLLECT at N+1; `byte_ready` is high in that cycle.
  - Minimum cost per word is 5 cycles (4 byte cycles + 1 WRITE).
- **Total load time:** with a continuous stream, a load of L words lasts 5L (+1 CHECK) + 1 DONE cycles. `cpu_stall` covers every one of those cycles.

## Configuration

- **Macro `IMEM_LOADER_CHECKSUM_EN` defined:**
  - After the last WRITE, the block enters CHECK with `byte_ready` = 1 and accepts one byte.
  - That byte is compared with the XOR of all data bytes in the load.
  - On mismatch, `load_err` is set and stays set until the next accepted `load_start` or reset. On match, `load_err` stays 0.
  - Either way the block proceeds to DONE.
- **Macro not defined:**
  - No CHECK state and no accumulator.
  - `load_err` is tied to 0.
  - Stream length is exactly 4L bytes.

## Test plan

- **Reset / passthrough:** reset, then `fetch_a` = 8 with memory word 2 = 32'hE080_2001 → `fetch_rd` = 32'hE080_2001 the same cycle; `cpu_stall` = 0.
- **Two-word load:** `load_start`, `load_len` = 2, bytes E3,A0,00,0A,E3,A0,10,05 streamed continuously → `mem_we` pulses at word addresses 0 and 4 with 32'hE3A0_000A and 32'hE3A0_1005; `load_done` pulses once; `cpu_stall` high for exactly 11 cycles.
- **Producer gaps:** `byte_valid` deasserted for 3 cycles between bytes 2 and 3 → identical written words; load lasts 3 cycles longer; no byte is dropped or duplicated.
- **Length clamp:** `load_len` = 0 with DEPTH = 64 → 64 writes, last at `mem_a` = 252; then `load_done`.
- **Reset mid-load:** reset asserted after 6 bytes of a 2-word load → only word 0 is written; RUN on the next cycle; `cpu_stall` = 0; no `load_done`.
- **Checksum (macro defined):** a 1-word load of 01,02,03,04 followed by 04 → `load_err` = 0; the same load followed by 05 → `load_err` = 1 with the `load_done` pulse, held until the next `load_start`.
